// File: rtl/bridge_pkg.sv
// Shared types and constants for the processor-bus to peripheral bridge.
package bridge_pkg;

  // Width of the device index field taken from the word address.
  localparam int IDX_W = 3;

  // Largest number of device channels the HWInt[7:2] field can carry.
  localparam int MAX_DEV = 6;

  // Width of the wait-state counter.
  localparam int CNT_W = 8;

  // Default byte base of the device region.
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7E00;

  // Bridge request sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/bridge_decode.sv
// Combinational address decode: region match, device index and device hit.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int          N_DEV     = 2,
  parameter int          DEV_AW    = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic [31:DEV_AW+2] addr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               dev_hit_o
);

  localparam logic [IDX_W:0] N_DEV_L = (IDX_W + 1)'(N_DEV);

  logic region_hit;

  // Region compare above the device windows, index just above the word offset.
  always_comb begin
    region_hit = (addr_i[31:DEV_AW+5] == BASE_ADDR[31:DEV_AW+5]);
    idx_o      = addr_i[DEV_AW+4:DEV_AW+2];
    dev_hit_o  = region_hit && ({1'b0, idx_o} < N_DEV_L);
  end

endmodule

// File: rtl/sys_bridge.sv
// System bridge between the CPU processor bus and up to MAX_DEV peripherals.
// One request in flight; decode misses answer immediately with PrErr.
// Optional feature macro BRIDGE_TIMEOUT_EN: when defined, an 8-bit wait-state
// counter aborts an access after TIMEOUT_CYC unready cycles with PrErr set;
// when undefined, ACCESS waits for DevRdy indefinitely.
module sys_bridge
  import bridge_pkg::*;
#(
  parameter int          N_DEV       = 2,
  parameter int          DEV_AW      = 4,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  // processor side
  input  logic                  PrReq,
  input  logic [31:2]           PrAddr,
  input  logic [3:0]            BE,
  input  logic [31:0]           PrDOut,
  input  logic                  PrWe,
  output logic [31:0]           PrDIn,
  output logic                  PrRdy,
  output logic                  PrErr,
  output logic [7:2]            HWInt,
  // device side
  output logic [N_DEV-1:0]      DevSel,
  output logic [DEV_AW-1:0]     DevAddr,
  output logic [31:0]           DevWd,
  output logic [3:0]            DevBE,
  output logic                  DevWe,
  input  logic [N_DEV*32-1:0]   DevRd,
  input  logic [N_DEV-1:0]      DevRdy,
  input  logic [N_DEV-1:0]      DevIrq
);

  // Parameter legality, caught at elaboration.
  if (N_DEV < 1 || N_DEV > MAX_DEV) begin : g_bad_n_dev
    $error("sys_bridge: N_DEV must be 1..6");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("sys_bridge: TIMEOUT_CYC must be 1..255");
  end
  if (BASE_ADDR[DEV_AW+4:0] != '0) begin : g_bad_base
    $error("sys_bridge: BASE_ADDR not aligned to the device region size");
  end

  state_e               state_q, state_d;
  logic [DEV_AW-1:0]    addr_q, addr_d;
  logic [31:0]          wd_q, wd_d;
  logic [3:0]           be_q, be_d;
  logic                 we_q, we_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [MAX_DEV-1:0]   irq_q, irq_d;
`ifdef BRIDGE_TIMEOUT_EN
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_hit;
  logic [31:0]          sel_rd;
  logic                 sel_rdy;
  logic [N_DEV-1:0]     dev_sel;

  bridge_decode #(
    .N_DEV     (N_DEV),
    .DEV_AW    (DEV_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr_i    (PrAddr[31:DEV_AW+2]),
    .idx_o     (dec_idx),
    .dev_hit_o (dec_hit)
  );

  // Steer the latched device's read data and ready, and drive its select.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    sel_rd  = '0;
    sel_rdy = 1'b0;
    dev_sel = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_rd     = DevRd[32*i +: 32];
        sel_rdy    = DevRdy[i];
        dev_sel[i] = (state_q == ACCESS);
      end
    end
  end

  // Interrupt lines for implemented channels; unused HWInt bits stay zero.
  always_comb begin
    irq_d = '0;
    for (int i = 0; i < N_DEV; i++) begin
      irq_d[i] = DevIrq[i];
    end
  end

  // Request sequencer: latch on accept, wait for ready (or timeout), respond.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    we_d    = we_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (PrReq) begin
          addr_d = PrAddr[DEV_AW+1:2];
          wd_d   = PrDOut;
          be_d   = BE;
          we_d   = PrWe;
          idx_d  = dec_idx;
          if (dec_hit) begin
            state_d = ACCESS;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready is tested before the limit so a late ready still wins.
        if (sel_rdy) begin
          rdata_d = we_q ? 32'd0 : sel_rd;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      irq_q   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign DevSel  = dev_sel;
  assign DevAddr = addr_q;
  assign DevWd   = wd_q;
  assign DevBE   = be_q;
  assign DevWe   = (state_q == ACCESS) & we_q;

  assign PrRdy   = (state_q == RESP);
  assign PrErr   = PrRdy & err_q;
  assign PrDIn   = rdata_q;
  assign HWInt   = irq_q;

endmodule
